// File: rtl/group_burst_serializer.sv
// rtl/group_burst_serializer.sv - captures a GROUPS x GROUP_W word and streams a wrapped run of groups
//
// Purpose: accepts one wide word plus a start group, a burst length and a direction, then emits
//          len_m1+1 groups one per beat. The index steps up (dir=0) or down (dir=1) and wraps modulo GROUPS.
// Ports:
//   clk, rst_n                      rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready               input handshake; in_ready is high only while idle
//   in_data, start_sel, len_m1, dir input word and burst descriptor, captured on accept
//   out_valid/out_ready             output handshake
//   out_data, out_idx, out_last     current group, its index, and the final-beat flag
module group_burst_serializer #(
    parameter int GROUP_W = 10,
    parameter int GROUPS  = 4,
    parameter int SEL_W   = $clog2(GROUPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [GROUPS*GROUP_W-1:0] in_data,
    input  logic [SEL_W-1:0]          start_sel,
    input  logic [SEL_W-1:0]          len_m1,
    input  logic                      dir,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [GROUP_W-1:0]        out_data,
    output logic [SEL_W-1:0]          out_idx,
    output logic                      out_last
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(GROUPS - 1);

    state_t                    r_state;
    logic [GROUPS*GROUP_W-1:0] r_word;
    logic                      r_dir;
    logic [SEL_W-1:0]          r_rem;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [GROUP_W-1:0]        r_out_data;
    logic [SEL_W-1:0]          r_out_idx;
    logic                      r_out_last;

    logic [SEL_W-1:0]          w_start;
    logic [SEL_W-1:0]          w_len;
    logic [SEL_W-1:0]          w_next_idx;
    logic [GROUP_W-1:0]        w_in_group;
    logic [GROUP_W-1:0]        w_next_group;
    logic                      w_accept;
    logic                      w_take;

    // Out-of-range descriptors only exist for non-power-of-two GROUPS:
    // the start index folds back into range, the length saturates to a full word.
    always_comb begin
        w_start = SEL_W'(int'(start_sel) % GROUPS);
        w_len   = (int'(len_m1) > GROUPS - 1) ? LAST_IDX : len_m1;
    end

    // Wrapping step of the current index in the captured direction.
    always_comb begin
        w_next_idx = '0;
        if (r_dir) begin
            w_next_idx = (r_out_idx == '0) ? LAST_IDX : r_out_idx - SEL_W'(1);
        end else begin
            w_next_idx = (r_out_idx == LAST_IDX) ? '0 : r_out_idx + SEL_W'(1);
        end
    end

    // The first beat comes straight from the incoming word so it appears one cycle after accept.
    assign w_in_group   = in_data[int'(w_start) * GROUP_W +: GROUP_W];
    assign w_next_group = r_word[int'(w_next_idx) * GROUP_W +: GROUP_W];

    assign w_accept = in_valid & r_in_ready;
    assign w_take   = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_dir       <= 1'b0;
            r_rem       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_SEND;
                        r_word      <= in_data;
                        r_dir       <= dir;
                        r_rem       <= w_len;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_in_group;
                        r_out_idx   <= w_start;
                        r_out_last  <= (w_len == '0);
                    end else begin
                        // in_ready comes up on the first clock after reset release.
                        r_in_ready  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_take) begin
                        if (r_out_last) begin
                            // Data and index hold their last value; in_ready returns next cycle.
                            r_state     <= S_IDLE;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_rem       <= r_rem - SEL_W'(1);
                            r_out_idx   <= w_next_idx;
                            r_out_data  <= w_next_group;
                            r_out_last  <= (r_rem == SEL_W'(1));
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_group_burst_serializer.sv
// tb/tb_group_burst_serializer.sv - directed and randomized bursts checked against an index-arithmetic model
module tb_group_burst_serializer;

    localparam int GW = 10;
    localparam int G  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [G*GW-1:0] in_data = '0;
    logic [SW-1:0]   start_sel = '0;
    logic [SW-1:0]   len_m1 = '0;
    logic            dir = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [GW-1:0]   out_data;
    logic [SW-1:0]   out_idx;
    logic            out_last;

    int vectors = 0;
    int miscompares = 0;

    group_burst_serializer #(.GROUP_W(GW), .GROUPS(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start_sel (start_sel),
        .len_m1    (len_m1),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge. mode: 0 always ready, 1 random ready, 2 stall three cycles first.
    // hold keeps in_valid high with alt_word driven during the burst.
    task automatic burst(input logic [G*GW-1:0] word, input int s, input int l, input int d,
                         input int mode, input bit hold, input logic [G*GW-1:0] alt_word);
        int n;
        int k;
        int cyc;
        int idx;
        int last_idx;
        int waitc;
        bit r;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = word;
        start_sel = SW'(s);
        len_m1    = SW'(l);
        dir       = d[0];
        @(negedge clk);
        if (hold) in_data = alt_word;
        else in_valid = 1'b0;
        n = ((l > G - 1) ? G - 1 : l) + 1;
        k = 0;
        cyc = 0;
        last_idx = 0;
        while (k < n && cyc < 200) begin
            idx = d[0] ? ((((s % G) - k) % G) + G) % G : ((s % G) + k) % G;
            last_idx = idx;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_idx", 32'(out_idx), 32'(idx));
            check("out_data", 32'(out_data), 32'(word[idx*GW +: GW]));
            check("out_last", 32'(out_last), 32'(k == n - 1));
            check("in_ready_busy", 32'(in_ready), 32'd0);
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                default: r = (cyc >= 3);
            endcase
            out_ready = r;
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        out_ready = 1'b0;
        check("burst_beats", 32'(k), 32'(n));
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_last", 32'(out_last), 32'd0);
        check("post_idx_hold", 32'(out_idx), 32'(last_idx));
        check("post_data_hold", 32'(out_data), 32'(word[last_idx*GW +: GW]));
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [G*GW-1:0] w;
        logic [G*GW-1:0] alt;
        w   = {10'd4, 10'd3, 10'd2, 10'd1};
        alt = {10'd40, 10'd30, 10'd20, 10'd10};

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        burst(w, 0, 3, 0, 0, 1'b0, '0);
        burst(w, 2, 3, 0, 0, 1'b0, '0);
        burst(w, 1, 2, 1, 0, 1'b0, '0);
        burst(w, 3, 0, 0, 2, 1'b0, '0);
        burst(w, 0, 3, 0, 0, 1'b1, alt);
        burst(alt, 0, 3, 0, 0, 1'b0, '0);
        in_valid = 1'b0;

        // Reset in the middle of a burst.
        in_valid  = 1'b1;
        in_data   = w;
        start_sel = 2'd1;
        len_m1    = 2'd3;
        dir       = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_out_valid", 32'(out_valid), 32'd1);
        check("mid_out_idx", 32'(out_idx), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_idx", 32'(out_idx), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
        check("midrst_rel_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [G*GW-1:0] rw;
            rw = {$urandom, $urandom};
            burst(rw, int'($urandom_range(0, G - 1)), int'($urandom_range(0, G - 1)),
                  int'($urandom_range(0, 1)), 1, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
